// File: rtl/tone_pkg.sv
// tone_pkg: shared note codes, note period table and helpers for tone generation and measurement
package tone_pkg;
  typedef enum logic [1:0] {IDLE, FIRST, MEASURE, LOCKED} state_e;
  typedef enum logic [2:0] {NOTE_NONE, NOTE_C5, NOTE_D5, NOTE_E5, NOTE_F5, NOTE_G5, NOTE_A5, NOTE_B5} note_e;
  typedef logic [1:7][19:0] note_tbl_t;
  localparam note_tbl_t NOTE_PERIODS = {20'd191131, 20'd170300, 20'd151700, 20'd143184, 20'd127551, 20'd113636, 20'd101239};
  function automatic logic [20:0] abs_diff(input logic [20:0] a, input logic [20:0] b);
    return a > b ? a - b : b - a;
  endfunction
  function automatic note_e note_of(input logic [20:0] p, input note_tbl_t tbl, input logic [20:0] tol);
    note_e n;
    n = NOTE_NONE;
    for (int i = 7; i >= 1; i--)
      if (abs_diff(p, {1'b0, tbl[i]}) <= tol) n = note_e'(i[2:0]);
    return n;
  endfunction
endpackage

// File: rtl/edge_sync.sv
// edge_sync: two-flop synchronizer with rising-edge detection on the synchronized input
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);
  logic [2:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[1:0], din};
  always_ff @(posedge clk) sync_q <= rst ? 3'b000 : sync_d;
  assign rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/tone_meter.sv
// tone_meter: measures a square-wave tone period, locks on two matching periods and classifies the note
module tone_meter import tone_pkg::*; #(
  parameter int        TIMEOUT  = 2_000_000,
  parameter int        TOL      = 1024,
  parameter note_tbl_t NOTE_TBL = NOTE_PERIODS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        tone_in,
  output logic [19:0] period,
  output logic [2:0]  note,
  output logic        locked,
  output logic        update,
  output logic        silent
);
  localparam logic [20:0] TMO = 21'(TIMEOUT);
  localparam logic [20:0] TL = 21'(TOL);
  state_e state_q, state_d;
  logic [20:0] cnt_q, cnt_d, cand_q, cand_d;
  logic cand_ok_q, cand_ok_d;
  logic [19:0] period_q, period_d;
  logic [2:0] note_q, note_d;
  logic update_q, update_d, silent_q, silent_d;
  logic rise, acc, tmo;
  edge_sync u_sync (.clk(clk), .rst(rst), .din(tone_in), .rise(rise));
  always_comb begin
    acc = rise && state_q != IDLE && cnt_q >= 21'd4;
    tmo = !acc && state_q != IDLE && cnt_q == TMO;
    state_d = state_q;
    cand_d = cand_q;
    cand_ok_d = cand_ok_q;
    period_d = period_q;
    note_d = note_q;
    silent_d = acc ? 1'b0 : tmo ? 1'b1 : silent_q;
    cnt_d = (state_q == IDLE || !en) ? '0 : acc ? 21'd1 : cnt_q == TMO ? TMO : cnt_q + 21'd1;
    if (state_q == IDLE) begin
      state_d = FIRST;
    end else if (tmo) begin
      state_d = FIRST;
      cand_ok_d = 1'b0;
      period_d = '0;
      note_d = '0;
    end else if (acc) begin
      case (state_q)
        FIRST: begin
          state_d = MEASURE;
          cand_ok_d = 1'b0;
        end
        MEASURE: begin
          cand_d = cnt_q;
          cand_ok_d = 1'b1;
          if (cand_ok_q && abs_diff(cnt_q, cand_q) <= TL) begin
            state_d = LOCKED;
            period_d = cnt_q[19:0];
            note_d = note_of(cnt_q, NOTE_TBL, TL);
          end
        end
        LOCKED: begin
          if (abs_diff(cnt_q, {1'b0, period_q}) > TL) begin
            state_d = MEASURE;
            cand_d = cnt_q;
            cand_ok_d = 1'b1;
            period_d = '0;
            note_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (!en) begin
      state_d = IDLE;
      cand_ok_d = 1'b0;
      period_d = '0;
      note_d = '0;
    end
    update_d = (state_d == LOCKED) != (state_q == LOCKED);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cand_q <= '0;
      cand_ok_q <= 1'b0;
      period_q <= '0;
      note_q <= '0;
      update_q <= 1'b0;
      silent_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cand_q <= cand_d;
      cand_ok_q <= cand_ok_d;
      period_q <= period_d;
      note_q <= note_d;
      update_q <= update_d;
      silent_q <= silent_d;
    end
  end
  assign period = period_q;
  assign note = note_q;
  assign locked = state_q == LOCKED;
  assign update = update_q;
  assign silent = silent_q;
endmodule
